// File: rtl/alu_vec_pkg.sv
// alu_vec_pkg: opcode encoding and per-lane flag layout shared by the vector ALU files
package alu_vec_pkg;
    typedef enum logic [2:0] {
        OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR
    } opcode_e;
    localparam int FLAG_V = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_Z = 2;
    localparam int FLAG_N = 3;
    localparam int FLAGS_PER_LANE = 4;
endpackage

// File: rtl/alu_vec_pipe_if.sv
// alu_vec_pipe_if: operand/result handshake bundle for alu_vec_pipe.
// master drives operands, out_ready and sticky_clr; slave (the ALU) drives
// in_ready, out_valid, result, flags and sticky.
interface alu_vec_pipe_if import alu_vec_pkg::*; #(
    parameter int NUM_LANES = 16,
    parameter int LANE_W = 16
);
    localparam int VEC_W = NUM_LANES * LANE_W;
    logic in_valid;
    logic in_ready;
    logic [VEC_W-1:0] a;
    logic [VEC_W-1:0] b;
    opcode_e opcode;
    logic flag_scalar;
    logic sat;
    logic out_valid;
    logic out_ready;
    logic [VEC_W-1:0] result;
    logic [FLAGS_PER_LANE*NUM_LANES-1:0] flags;
    logic [FLAGS_PER_LANE*NUM_LANES-1:0] sticky;
    logic sticky_clr;
    modport master (
        output in_valid, a, b, opcode, flag_scalar, sat, out_ready, sticky_clr,
        input in_ready, out_valid, result, flags, sticky
    );
    modport slave (
        input in_valid, a, b, opcode, flag_scalar, sat, out_ready, sticky_clr,
        output in_ready, out_valid, result, flags, sticky
    );
endinterface

// File: rtl/alu_vec_lane.sv
// alu_vec_lane: combinational single-lane ALU.
// Ports: a, b operands; opcode; sat (signed saturation for ADD/SUB);
// result; flags {N,Z,C,V}.
module alu_vec_lane import alu_vec_pkg::*; #(
    parameter int LANE_W = 16
) (
    input  logic [LANE_W-1:0] a,
    input  logic [LANE_W-1:0] b,
    input  opcode_e opcode,
    input  logic sat,
    output logic [LANE_W-1:0] result,
    output logic [FLAGS_PER_LANE-1:0] flags
);
    localparam int SW = $clog2(LANE_W);
    localparam int M = LANE_W - 1;
    logic [LANE_W:0] sum, diff;
    logic [2*LANE_W-1:0] prod, shl_full, shr_full;
    logic [SW:0] sh;
    logic big, c, v;
    logic [LANE_W-1:0] raw, sat_val;
    assign sum = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};
    assign prod = {{LANE_W{1'b0}}, a} * {{LANE_W{1'b0}}, b};
    assign sh = b[SW:0];
    assign big = sh >= (SW+1)'(LANE_W);
    // Widened shifts keep the last bit shifted out just beyond the lane boundary
    assign shl_full = {{LANE_W{1'b0}}, a} << sh;
    assign shr_full = {a, {LANE_W{1'b0}}} >> sh;
    // On overflow the true result has the sign of a, so clamp toward it
    assign sat_val = {a[M], {(LANE_W-1){!a[M]}}};
    always_comb begin
        raw = '0;
        c = 1'b0;
        v = 1'b0;
        case (opcode)
            OP_ADD: begin
                raw = sum[M:0];
                c = sum[LANE_W];
                v = (a[M] == b[M]) && (sum[M] != a[M]);
            end
            OP_SUB: begin
                raw = diff[M:0];
                c = !diff[LANE_W];
                v = (a[M] != b[M]) && (diff[M] != a[M]);
            end
            OP_MUL: begin
                raw = prod[M:0];
                c = |prod[2*LANE_W-1:LANE_W];
            end
            OP_AND: raw = a & b;
            OP_OR:  raw = a | b;
            OP_XOR: raw = a ^ b;
            OP_SHL: begin
                raw = big ? '0 : shl_full[M:0];
                c = !big && shl_full[LANE_W];
            end
            OP_SHR: begin
                raw = big ? '0 : shr_full[2*LANE_W-1:LANE_W];
                c = !big && shr_full[M];
            end
            default: raw = '0;
        endcase
    end
    // v is only ever set for ADD/SUB, so it alone gates saturation
    assign result = (sat && v) ? sat_val : raw;
    always_comb begin
        flags = '0;
        flags[FLAG_N] = result[M];
        flags[FLAG_Z] = result == '0;
        flags[FLAG_C] = c;
        flags[FLAG_V] = v;
    end
endmodule

// File: rtl/alu_vec_pipe.sv
// alu_vec_pipe: two-stage pipelined vector ALU with valid/ready handshake.
// Ports: clk; rst_n (async, active-low); bus (alu_vec_pipe_if.slave) carrying
// operands/opcode/flag_scalar/sat in, result/flags/sticky out, and the
// in_valid/in_ready, out_valid/out_ready handshakes.
module alu_vec_pipe import alu_vec_pkg::*; #(
    parameter int NUM_LANES = 16,
    parameter int LANE_W = 16
) (
    input logic clk,
    input logic rst_n,
    alu_vec_pipe_if.slave bus
);
    localparam int VEC_W = NUM_LANES * LANE_W;
    localparam int FW = FLAGS_PER_LANE * NUM_LANES;
    logic s1_valid, s1_sat, s2_valid, s1_adv, s2_adv, out_hs;
    logic [VEC_W-1:0] s1_a, s1_b, b_eff, lane_res, res_q;
    logic [FW-1:0] lane_flags, flags_q, sticky_q;
    opcode_e s1_op;
    assign s2_adv = !s2_valid || bus.out_ready;
    assign s1_adv = !s1_valid || s2_adv;
    assign out_hs = s2_valid && bus.out_ready;
    assign bus.in_ready = s1_adv;
    assign bus.out_valid = s2_valid;
    assign bus.result = res_q;
    assign bus.flags = flags_q;
    assign bus.sticky = sticky_q;
    assign b_eff = bus.flag_scalar ? {NUM_LANES{bus.b[LANE_W-1:0]}} : bus.b;
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        alu_vec_lane #(.LANE_W(LANE_W)) u_lane (
            .a(s1_a[LANE_W*i +: LANE_W]),
            .b(s1_b[LANE_W*i +: LANE_W]),
            .opcode(s1_op),
            .sat(s1_sat),
            .result(lane_res[LANE_W*i +: LANE_W]),
            .flags(lane_flags[FLAGS_PER_LANE*i +: FLAGS_PER_LANE])
        );
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a <= '0;
            s1_b <= '0;
            s1_op <= OP_ADD;
            s1_sat <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_a <= bus.a;
                s1_b <= b_eff;
                s1_op <= bus.opcode;
                s1_sat <= bus.sat;
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            res_q <= '0;
            flags_q <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                res_q <= lane_res;
                flags_q <= lane_flags;
            end
        end
    end
    // Clear wins over accumulation, but the flags delivered that same cycle survive
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sticky_q <= '0;
        else if (bus.sticky_clr) sticky_q <= out_hs ? flags_q : '0;
        else if (out_hs) sticky_q <= sticky_q | flags_q;
    end
endmodule

// File: tb/tb_alu_vec_pipe.sv
// tb_alu_vec_pipe: randomized + directed bench for alu_vec_pipe against a behavioural lane model
module tb_alu_vec_pipe;
    import alu_vec_pkg::*;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;

    alu_vec_pipe_if #(.NUM_LANES(16), .LANE_W(16)) bus ();
    alu_vec_pipe_if #(.NUM_LANES(4), .LANE_W(8)) sbus ();
    alu_vec_pipe #(.NUM_LANES(16), .LANE_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    alu_vec_pipe #(.NUM_LANES(4), .LANE_W(8)) dut_s (.clk(clk), .rst_n(rst_n), .bus(sbus));

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference lane: {N,Z,C,V,result} from plain integer arithmetic on 16-bit lanes
    function automatic logic [19:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input opcode_e op, input logic sat);
        int ua, ub, sa, sb, s, r, n;
        longint p;
        bit c, v;
        logic [15:0] res;
        ua = int'(a); ub = int'(b); sa = int'($signed(a)); sb = int'($signed(b));
        n = ub % 32; c = 0; v = 0; r = 0;
        case (op)
            OP_ADD: begin
                r = ua + ub; c = r > 65535; s = sa + sb;
                v = s > 32767 || s < -32768;
                if (sat && v) r = s > 0 ? 32'h7FFF : 32'h8000;
            end
            OP_SUB: begin
                r = ua - ub; c = ua >= ub; s = sa - sb;
                v = s > 32767 || s < -32768;
                if (sat && v) r = s > 0 ? 32'h7FFF : 32'h8000;
            end
            OP_MUL: begin
                p = longint'(ua) * longint'(ub); r = int'(p % 65536); c = p > 65535;
            end
            OP_AND: r = ua & ub;
            OP_OR:  r = ua | ub;
            OP_XOR: r = ua ^ ub;
            OP_SHL: if (n < 16) begin r = ua << n; c = n > 0 && ua[16-n]; end
            OP_SHR: if (n < 16) begin r = ua >> n; c = n > 0 && ua[n-1]; end
            default: r = 0;
        endcase
        res = r[15:0];
        return {res[15], res == 16'h0, c, v, res};
    endfunction

    function automatic logic [15:0] rl();
        case ($urandom_range(0, 6))
            0: return 16'h7FFF;
            1: return 16'h8000;
            2: return 16'hFFFF;
            3: return 16'h0000;
            4: return 16'($urandom_range(0, 31));
            default: return 16'($urandom);
        endcase
    endfunction

    function automatic logic [255:0] rvec();
        logic [255:0] v;
        for (int l = 0; l < 16; l++) v[16*l +: 16] = rl();
        return v;
    endfunction

    logic [255:0] exp_res[$];
    logic [63:0] exp_flg[$];
    logic [63:0] sticky_m = '0;

    // Scoreboard: settles 1 time unit after each falling edge, when all inputs are stable
    always @(negedge clk) begin
        logic [255:0] beff, r;
        logic [63:0] f;
        logic [19:0] m;
        #1;
        if (!rst_n) begin
            chk("rst_out_valid", 256'(bus.out_valid), 256'(0));
            chk("rst_result", bus.result, 256'(0));
            chk("rst_flags", 256'(bus.flags), 256'(0));
            chk("rst_sticky", 256'(bus.sticky), 256'(0));
            exp_res.delete();
            exp_flg.delete();
            sticky_m = '0;
        end else begin
            chk("sticky", 256'(bus.sticky), 256'(sticky_m));
            if (bus.out_valid) begin
                if (exp_res.size() == 0) chk("spurious_out", 256'(1), 256'(0));
                else begin
                    chk("result", bus.result, exp_res[0]);
                    chk("flags", 256'(bus.flags), 256'(exp_flg[0]));
                    if (bus.out_ready) begin
                        sticky_m = bus.sticky_clr ? exp_flg[0] : (sticky_m | exp_flg[0]);
                        void'(exp_res.pop_front());
                        void'(exp_flg.pop_front());
                    end
                end
            end
            if (bus.sticky_clr && !(bus.out_valid && bus.out_ready)) sticky_m = '0;
            if (bus.in_valid && bus.in_ready) begin
                beff = bus.flag_scalar ? {16{bus.b[15:0]}} : bus.b;
                for (int l = 0; l < 16; l++) begin
                    m = model(bus.a[16*l +: 16], beff[16*l +: 16], bus.opcode, bus.sat);
                    r[16*l +: 16] = m[15:0];
                    f[4*l +: 4] = m[19:16];
                end
                exp_res.push_back(r);
                exp_flg.push_back(f);
            end
        end
    end

    task automatic send(input opcode_e op, input logic [255:0] a, input logic [255:0] b,
                        input logic sc, input logic st);
        @(negedge clk);
        bus.in_valid = 1'b1; bus.opcode = op; bus.a = a; bus.b = b;
        bus.flag_scalar = sc; bus.sat = st; bus.sticky_clr = 1'b0;
        for (int k = 0; k < 50; k++) begin
            #1;
            if (bus.in_ready) return;
            @(negedge clk);
        end
        chk("send_timeout", 256'(0), 256'(1));
    endtask

    task automatic run_one(input string nm, input opcode_e op, input logic [255:0] a,
                           input logic [255:0] b, input logic sc, input logic st,
                           input logic [15:0] er, input logic [3:0] ef, input logic clr);
        bus.out_ready = 1'b1;
        send(op, a, b, sc, st);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #2 chk({nm, "_lat1"}, 256'(bus.out_valid), 256'(0));
        @(negedge clk);
        bus.sticky_clr = clr;
        #2 chk({nm, "_lat2"}, 256'(bus.out_valid), 256'(1));
        chk({nm, "_res0"}, 256'(bus.result[15:0]), 256'(er));
        chk({nm, "_flg0"}, 256'(bus.flags[3:0]), 256'(ef));
        @(negedge clk);
        bus.sticky_clr = 1'b0;
    endtask

    task automatic small_add(input logic st, input logic [31:0] er, input logic [15:0] ef);
        @(negedge clk);
        sbus.in_valid = 1'b1; sbus.a = {4{8'h7F}}; sbus.b = {4{8'h01}}; sbus.sat = st;
        #1 chk("s_in_ready", 256'(sbus.in_ready), 256'(1));
        @(negedge clk);
        sbus.in_valid = 1'b0;
        @(negedge clk);
        #2 chk("s_valid", 256'(sbus.out_valid), 256'(1));
        chk("s_result", 256'(sbus.result), 256'(er));
        chk("s_flags", 256'(sbus.flags), 256'(ef));
    endtask

    initial begin
        int sent;
        bit blocked;
        logic [255:0] bv;
        bus.in_valid = 0; bus.a = '0; bus.b = '0; bus.opcode = OP_ADD;
        bus.flag_scalar = 0; bus.sat = 0; bus.out_ready = 1; bus.sticky_clr = 0;
        sbus.in_valid = 0; sbus.a = '0; sbus.b = '0; sbus.opcode = OP_ADD;
        sbus.flag_scalar = 0; sbus.sat = 0; sbus.out_ready = 1; sbus.sticky_clr = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        // Hand-derived values pinning the reference model
        chk("m_add", 256'(model(16'h7FFF, 16'h0001, OP_ADD, 0)), 256'({4'b1001, 16'h8000}));
        chk("m_adds", 256'(model(16'h7FFF, 16'h0001, OP_ADD, 1)), 256'({4'b0001, 16'h7FFF}));
        chk("m_sub", 256'(model(16'h0003, 16'h0005, OP_SUB, 0)), 256'({4'b1000, 16'hFFFE}));
        chk("m_subz", 256'(model(16'h1234, 16'h1234, OP_SUB, 0)), 256'({4'b0110, 16'h0000}));
        chk("m_shl", 256'(model(16'h4001, 16'h0002, OP_SHL, 0)), 256'({4'b0010, 16'h0004}));
        chk("m_shr", 256'(model(16'h4001, 16'h0010, OP_SHR, 0)), 256'({4'b0100, 16'h0000}));
        chk("m_mul", 256'(model(16'h0100, 16'h0100, OP_MUL, 0)), 256'({4'b0110, 16'h0000}));
        run_one("add", OP_ADD, {16{16'h7FFF}}, {16{16'h0001}}, 0, 0, 16'h8000, 4'b1001, 0);
        run_one("adds", OP_ADD, {16{16'h7FFF}}, {16{16'h0001}}, 0, 1, 16'h7FFF, 4'b0001, 0);
        run_one("sub", OP_SUB, {16{16'h0003}}, {16{16'h0005}}, 0, 0, 16'hFFFE, 4'b1000, 0);
        run_one("subz", OP_SUB, {16{16'h1234}}, {16{16'h1234}}, 0, 0, 16'h0000, 4'b0110, 0);
        bv = rvec(); bv[15:0] = 16'h0002;
        run_one("shl_bc", OP_SHL, {16{16'h4001}}, bv, 1, 0, 16'h0004, 4'b0010, 0);
        chk("shl_bc_all", bus.result, {16{16'h0004}});
        bv = rvec(); bv[15:0] = 16'h0010;
        run_one("shr16", OP_SHR, {16{16'h4001}}, bv, 1, 0, 16'h0000, 4'b0100, 0);
        run_one("mul", OP_MUL, {16{16'h0100}}, {16{16'h0100}}, 0, 0, 16'h0000, 4'b0110, 1);
        #1 chk("mul_sticky", 256'(bus.sticky[3:0]), 256'(4'b0110));
        small_add(0, {4{8'h80}}, {4{4'b1001}});
        small_add(1, {4{8'h7F}}, {4{4'b0001}});
        // Back-to-back ops with a consumer stall
        sent = 0; blocked = 0;
        for (int c = 0; c < 40 && sent < 8; c++) begin
            @(negedge clk);
            bus.out_ready = !(c >= 3 && c <= 6);
            bus.in_valid = 1'b1; bus.a = rvec(); bus.b = rvec();
            bus.opcode = opcode_e'($urandom_range(0, 7)); bus.sat = 1'($urandom);
            bus.flag_scalar = 0;
            #1;
            if (!bus.in_ready) blocked = 1;
            if (bus.in_ready) sent++;
        end
        @(negedge clk);
        bus.in_valid = 0; bus.out_ready = 1;
        repeat (6) @(negedge clk);
        chk("stall_blocked", 256'(blocked), 256'(1));
        chk("stall_sent", 256'(sent), 256'(8));
        chk("stall_drained", 256'(exp_res.size()), 256'(0));
        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            bus.in_valid = $urandom_range(0, 3) != 0;
            bus.out_ready = $urandom_range(0, 3) != 0;
            bus.sticky_clr = $urandom_range(0, 15) == 0;
            bus.a = rvec(); bus.b = rvec();
            bus.opcode = opcode_e'($urandom_range(0, 7));
            bus.sat = 1'($urandom); bus.flag_scalar = $urandom_range(0, 3) == 0;
        end
        @(negedge clk);
        bus.in_valid = 0; bus.out_ready = 1; bus.sticky_clr = 0;
        repeat (6) @(negedge clk);
        chk("rand_drained", 256'(exp_res.size()), 256'(0));
        // Reset with two ops in flight
        bus.out_ready = 0;
        send(OP_ADD, rvec(), rvec(), 0, 0);
        send(OP_XOR, rvec(), rvec(), 0, 0);
        @(negedge clk);
        bus.in_valid = 0;
        #2 chk("inflight_valid", 256'(bus.out_valid), 256'(1));
        #1 rst_n = 1'b0;
        #1 chk("async_rst_valid", 256'(bus.out_valid), 256'(0));
        repeat (2) @(negedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        bus.out_ready = 1;
        #1 chk("ready_after_rst", 256'(bus.in_ready), 256'(1));
        repeat (8) @(negedge clk);
        #2 chk("no_ghost_out", 256'(bus.out_valid), 256'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end
endmodule

// File: doc/alu_vec_pipe.md
Name: alu_vec_pipe

Overview:
Parametrised, pipelined vector ALU: NUM_LANES independent lanes of LANE_W bits, two register stages, valid/ready handshake on input and output. Adds signed saturation, shift ops and sticky per-lane flags. Sits in the vector execute stage of the datapath, fed by the vector register file read port and draining into writeback; the writeback stall drives out_ready.

Parameters:
NUM_LANES, 16, number of lanes (>=1)
LANE_W, 16, bits per lane (>=4, power of 2)
VEC_W, NUM_LANES*LANE_W, derived operand width (localparam, not overridable)

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  reset, asynchronous assert, active-low
in_valid  in  1  operand set offered
in_ready  out  1  block accepts this cycle
a  in  VEC_W  operand A; lane i = a[LANE_W*i +: LANE_W]
b  in  VEC_W  operand B, same packing
opcode  in  3  operation, see Behaviour
flag_scalar  in  1  1: lane 0 of b is broadcast to every lane
sat  in  1  1: ADD/SUB saturate, signed
out_valid  out  1  result/flags valid
out_ready  in  1  consumer accepts
result  out  VEC_W  lane results
flags  out  4*NUM_LANES  lane i = flags[4i+3:4i] = {N,Z,C,V}
sticky  out  4*NUM_LANES  OR of all flags delivered since last clear
sticky_clr  in  1  clear sticky (synchronous)

Behaviour:
- Clock is clk; reset is rst_n, asynchronous and active-low. During reset: s1_valid=s2_valid=0, out_valid=0, result=0, flags=0, sticky=0. in_ready is 1 in the first cycle after release.
- Stage 1 (S1): on in_valid&&in_ready, register a, effective b (broadcast applied at capture), opcode, sat.
- Stage 2 (S2): combinational lane compute of S1 registered into result/flags; out_valid = s2_valid.
- Latency: accepted in cycle T -> out_valid in T+2 with no stalls. Throughput 1/cycle.
- Advance: s2_adv = !s2_valid || out_ready; s1_adv = !s1_valid || s2_adv; in_ready = s1_adv. in_ready has a combinational path from out_ready (no skid buffer). Stalled stages hold data bit-exact.
- Opcodes per lane: 000 ADD, 001 SUB (a-b), 010 MUL (low LANE_W of unsigned product), 011 AND, 100 OR, 101 XOR, 110 SHL, 111 SHR logical. Shift amount = b[$clog2(LANE_W):0] unsigned. Amounts >= LANE_W give result 0.
- N = result MSB. Z = (result==0).
- C: ADD carry-out. SUB 1 when a>=b unsigned (no borrow). MUL 1 when high half of product nonzero. SHL/SHR last bit shifted out (0 if amount 0 or >=LANE_W). Logic ops 0.
- V: ADD/SUB signed overflow, computed before saturation. All other ops 0.
- sat=1 and V=1 on ADD/SUB: result clamps to signed max 0x7FFF / min 0x8000 (LANE_W=16), sign taken from a. Flags are computed on the clamped result except V (stays 1) and C (unsaturated).
- sat is ignored for other opcodes.
- sticky: updates on each out_valid&&out_ready handshake, sticky |= flags. sticky_clr on the same cycle as a handshake: clear wins, then that handshake's flags are ORed into the cleared value (result = flags).
- Reset mid-operation discards all in-flight ops; no partial output appears.

Decomposition:
- Package alu_vec_pkg: opcode enum (OP_ADD..OP_SHR), flag bit-index constants (FLAG_V=0, FLAG_C=1, FLAG_Z=2, FLAG_N=3), FLAGS_PER_LANE=4.
- Sub-module alu_vec_lane: combinational single lane, parameter LANE_W, inputs a, b, opcode, sat; outputs result, flags. Instantiated NUM_LANES times via generate.
- Pipeline registers, handshake and sticky logic live in the top module.

Test Plan:
1. Reset then ADD lane0 a=0x7FFF b=0x0001, sat=0: result 0x8000, flags {N1,Z0,C0,V1} at T+2. Repeat with sat=1: result 0x7FFF, {N0,Z0,C0,V1}.
2. SUB a=0x0003 b=0x0005 on all 16 lanes: result 0xFFFE each, {N1,Z0,C0,V0}. Then a=b=0x1234: result 0, {N0,Z1,C1,V0}.
3. flag_scalar=1, b lane0=0x0002, other b lanes garbage, opcode SHL, a lanes=0x4001: every lane 0x0004, C=1. Then SHR by 16: result 0, C=0, Z=1.
4. Back-to-back 8 ops with out_ready held low for cycles 3-6: in_ready drops once both stages are full, no op lost or duplicated, output order matches input order, held outputs stable while stalled.
5. MUL a=0x0100 b=0x0100: result 0x0000, C=1, Z=1. Assert sticky_clr on that handshake: sticky lane = 4'b0110.
6. Assert rst_n low with 2 ops in flight: out_valid=0 asynchronously, and nothing is emitted after release. Re-run scenario 1 with NUM_LANES=4, LANE_W=8 (0x7F+0x01 sat -> 0x7F).
